// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types, constants and helpers for the fetch program counter
//
// Purpose : state encoding for the pc_unit FSM, instruction length and the
//           4-byte alignment check used on every redirect target.
// Contents: pc_state_e, ILEN_BYTES, is_aligned4()

package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int ILEN_BYTES = 4;

  // Only the two low address bits decide 4-byte alignment, so the helper
  // takes just those and stays independent of XLEN.
  function automatic logic is_aligned4(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack for call/return prediction
//
// Purpose : RAS_DEPTH-entry circular stack. A push when full overwrites the
//           oldest entry; a pop on empty is ignored; push+pop together
//           replaces the top entry. All updates are qualified by en_i.
// Ports   : clk, rst (sync, active-low)
//           en_i     - update enable (fetch address valid this cycle)
//           clear_i  - drop all entries (trap)
//           push_i   - push data_i
//           pop_i    - pop the top entry
//           data_i   - return address to push
//           top_o    - current top entry, 0 when empty
//           empty_o  - stack holds no entries

module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we;
  logic [PW-1:0]   waddr;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    we    = 1'b0;
    waddr = ptr_q;
    if (en_i) begin
      if (clear_i) begin
        ptr_d = '0;
        cnt_d = '0;
      end else if (push_i && pop_i && (cnt_q != '0)) begin
        // Return and call in one fetch: swap the top, depth unchanged.
        we    = 1'b1;
        waddr = ptr_q;
      end else if (push_i) begin
        // Pointer wraps naturally; when full this lands on the oldest entry.
        ptr_d = ptr_q + PW'(1);
        we    = 1'b1;
        waddr = ptr_q + PW'(1);
        if (cnt_q != CW'(RAS_DEPTH)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (pop_i && (cnt_q != '0)) begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries are don't-care while the count excludes them, so no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= data_i;
    end
  end

  assign empty_o = (cnt_q == '0);
  assign top_o   = empty_o ? '0 : mem_q[ptr_q];

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with redirect arbitration
//
// Purpose : owns the fetch address register; selects the next PC from
//           trap, jalr, branch, halt, stall and sequential increment;
//           rejects misaligned redirects to TRAP_VECTOR with a one-cycle
//           misalign_err pulse. Optional RAS enabled by macro PC_RAS_EN.
// Ports   : clk, rst (sync, active-low)
//           stall, br_taken/br_target, jalr/jalr_target, trap,
//           halt_req, resume, ras_push, ras_pop         - inputs
//           pc, pc_plus4, fetch_valid, misalign_err,
//           ras_top, ras_empty                          - outputs

module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jalr,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            trap,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            misalign_err,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fv_q, fv_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] jalr_eff;
  logic [XLEN-1:0] pc_inc;

  assign pc_inc   = pc_q + XLEN'(ILEN_BYTES);
  assign jalr_eff = {jalr_target[XLEN-1:1], 1'b0};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fv_d    = fv_q;
    mis_d   = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        fv_d    = 1'b1;
      end
      RUN: begin
        if (trap) begin
          pc_d = TRAP_VECTOR;
        end else if (jalr) begin
          if (!is_aligned4(jalr_eff[1:0])) begin
            pc_d  = TRAP_VECTOR;
            mis_d = 1'b1;
          end else begin
            pc_d = jalr_eff;
          end
        end else if (br_taken) begin
          if (!is_aligned4(br_target[1:0])) begin
            pc_d  = TRAP_VECTOR;
            mis_d = 1'b1;
          end else begin
            pc_d = br_target;
          end
        end else if (halt_req) begin
          state_d = HALT;
          fv_d    = 1'b0;
        end else if (!stall) begin
          pc_d = pc_inc;
        end
      end
      HALT: begin
        if (trap) begin
          pc_d    = TRAP_VECTOR;
          state_d = RUN;
          fv_d    = 1'b1;
        end else if (resume) begin
          state_d = RUN;
          fv_d    = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
        fv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      fv_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fv_q    <= fv_d;
      mis_q   <= mis_d;
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_inc;
  assign fetch_valid  = fv_q;
  assign misalign_err = mis_q;

`ifdef PC_RAS_EN
  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .en_i    (fv_q),
    .clear_i (trap),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_inc),
    .top_o   (ras_top),
    .empty_o (ras_empty)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras;
  assign unused_ras = ras_push ^ ras_pop;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit

module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, br_taken = 1'b0, jalr = 1'b0, trap = 1'b0;
  logic        halt_req = 1'b0, resume = 1'b0, ras_push = 1'b0, ras_pop = 1'b0;
  logic [31:0] br_target = '0, jalr_target = '0;
  logic [31:0] pc, pc_plus4, ras_top;
  logic        fetch_valid, misalign_err, ras_empty;

  always #5 clk = ~clk;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_1000),
    .TRAP_VECTOR  (32'h0000_0100),
    .RAS_DEPTH    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jalr         (jalr),
    .jalr_target  (jalr_target),
    .trap         (trap),
    .halt_req     (halt_req),
    .resume       (resume),
    .ras_push     (ras_push),
    .ras_pop      (ras_pop),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .misalign_err (misalign_err),
    .ras_top      (ras_top),
    .ras_empty    (ras_empty)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        fv;
    logic        mis;
    logic        rempty;
    logic [31:0] rtop;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: every expectation describes the state after one rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, "pc", pc, e.pc);
      chk(e.name, "pc_plus4", pc_plus4, e.pc + 32'd4);
      chk(e.name, "fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
      chk(e.name, "misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
      chk(e.name, "ras_empty", {31'd0, ras_empty}, {31'd0, e.rempty});
      chk(e.name, "ras_top", ras_top, e.rtop);
    end
  end

  task automatic idle();
    stall = 0; br_taken = 0; jalr = 0; trap = 0;
    halt_req = 0; resume = 0; ras_push = 0; ras_pop = 0;
    br_target = '0; jalr_target = '0;
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic stepr(input string nm, input logic [31:0] epc, input logic fv,
                       input logic mis, input logic re, input logic [31:0] rt);
    exp_t e;
    e.name = nm; e.pc = epc; e.fv = fv; e.mis = mis; e.rempty = re; e.rtop = rt;
    q.push_back(e);
    @(negedge clk);
    idle();
  endtask

  task automatic step(input string nm, input logic [31:0] epc, input logic fv, input logic mis);
    stepr(nm, epc, fv, mis, 1'b1, 32'h0);
  endtask

  initial begin
    idle();
    @(negedge clk);
    rst = 0;                                step("reset", 32'h1000, 0, 0);
    rst = 1;                                step("boot_to_run", 32'h1000, 1, 0);
                                            step("seq1", 32'h1004, 1, 0);
                                            step("seq2", 32'h1008, 1, 0);
    br_taken = 1; br_target = 32'h2000; stall = 1;
                                            step("br_over_stall", 32'h2000, 1, 0);
    for (int i = 0; i < 3; i++) begin
      stall = 1;                            step("stall_hold", 32'h2000, 1, 0);
    end
    jalr = 1; jalr_target = 32'h3001;       step("jalr_bit0", 32'h3000, 1, 0);
    jalr = 1; jalr_target = 32'h3002;       step("jalr_misalign", 32'h0100, 1, 1);
                                            step("mis_pulse_end", 32'h0104, 1, 0);
    br_taken = 1; br_target = 32'h2002;     step("br_misalign", 32'h0100, 1, 1);
                                            step("after_br_mis", 32'h0104, 1, 0);
    br_taken = 1; br_target = 32'h0040;     step("br_to_40", 32'h0040, 1, 0);
    halt_req = 1;                           step("halt", 32'h0040, 0, 0);
    br_taken = 1; br_target = 32'h0080; stall = 1;
                                            step("halt_ignores_br", 32'h0040, 0, 0);
                                            step("halt_hold", 32'h0040, 0, 0);
    resume = 1;                             step("resume", 32'h0040, 1, 0);
                                            step("after_resume", 32'h0044, 1, 0);
    trap = 1; jalr = 1; jalr_target = 32'h0500;
                                            step("trap_over_jalr", 32'h0100, 1, 0);
    halt_req = 1; br_taken = 1; br_target = 32'h0600;
                                            step("br_over_halt", 32'h0600, 1, 0);
    halt_req = 1;                           step("halt2", 32'h0600, 0, 0);
    trap = 1;                               step("trap_in_halt", 32'h0100, 1, 0);
    br_taken = 1; br_target = 32'hFFFF_FFFC;
                                            step("br_top", 32'hFFFF_FFFC, 1, 0);
                                            step("wrap", 32'h0000_0000, 1, 0);
                                            step("after_wrap", 32'h0000_0004, 1, 0);
    rst = 0; trap = 1;                      step("reset_over_trap", 32'h1000, 0, 0);
    rst = 1;                                step("reboot", 32'h1000, 1, 0);
`ifdef PC_RAS_EN
    br_taken = 1; br_target = 32'h10;       step("ras_br10", 32'h10, 1, 0);
    ras_push = 1; br_taken = 1; br_target = 32'h20; stepr("push1", 32'h20, 1, 0, 0, 32'h14);
    ras_push = 1; br_taken = 1; br_target = 32'h30; stepr("push2", 32'h30, 1, 0, 0, 32'h24);
    ras_push = 1; br_taken = 1; br_target = 32'h40; stepr("push3", 32'h40, 1, 0, 0, 32'h34);
    ras_push = 1; br_taken = 1; br_target = 32'h50; stepr("push4", 32'h50, 1, 0, 0, 32'h44);
    ras_push = 1; br_taken = 1; br_target = 32'h60; stepr("push5", 32'h60, 1, 0, 0, 32'h54);
    ras_pop = 1;                            stepr("pop1", 32'h64, 1, 0, 0, 32'h44);
    ras_pop = 1;                            stepr("pop2", 32'h68, 1, 0, 0, 32'h34);
    ras_pop = 1;                            stepr("pop3", 32'h6C, 1, 0, 0, 32'h24);
    ras_pop = 1;                            stepr("pop4", 32'h70, 1, 0, 1, 32'h0);
    ras_push = 1;                           stepr("push6", 32'h74, 1, 0, 0, 32'h74);
    trap = 1;                               stepr("trap_clear", 32'h100, 1, 0, 1, 32'h0);
`else
    ras_push = 1;                           step("push_ignored", 32'h1004, 1, 0);
    ras_pop = 1;                            step("pop_ignored", 32'h1008, 1, 0);
`endif
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
